// File: rtl/mem_fill_arbiter_if.sv
// Bundle of requester, store and memory-port signals around mem_fill_arbiter.
// master: caches + memory model side; slave: the arbiter itself.
interface mem_fill_arbiter_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16
);
  logic              d_miss;
  logic [AWIDTH-1:0] d_miss_addr;
  logic              i_miss;
  logic [AWIDTH-1:0] i_miss_addr;
  logic              st_req;
  logic [AWIDTH-1:0] st_addr;
  logic [DWIDTH-1:0] st_data;
  logic              mem_valid;
  logic              mem_en;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              d_fill_wen;
  logic              d_tag_wen;
  logic              i_fill_wen;
  logic              i_tag_wen;
  logic [2:0]        fill_word;
  logic              st_ack;
  logic              busy;

  // Handshake: misses and st_req are level requests held by the requester until
  // the matching *_tag_wen / st_ack pulse; there is no backpressure on memory data.
  modport master (
    output d_miss, d_miss_addr, i_miss, i_miss_addr, st_req, st_addr, st_data, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, d_fill_wen, d_tag_wen, i_fill_wen,
           i_tag_wen, fill_word, st_ack, busy
  );

  modport slave (
    input  d_miss, d_miss_addr, i_miss, i_miss_addr, st_req, st_addr, st_data, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, d_fill_wen, d_tag_wen, i_fill_wen,
           i_tag_wen, fill_word, st_ack, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbiter/sequencer for the shared pipelined memory: 8-word cache fills and write-through stores.
// Optional MEM_ARB_FAIR_EN: alternate grants between the data side (D miss/store) and I miss.
module mem_fill_arbiter #(
  parameter int AWIDTH  = 16,
  parameter int DWIDTH  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_fill_arbiter_if.slave   bus,
  output logic [2:0]          state_dbg
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_fill_arbiter: MEM_LAT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_TAG   = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic                tgt_i;          // 0: D-cache fill, 1: I-cache fill
  logic [AWIDTH-5:0]   base_hi;
  logic [2:0]          issue_cnt;
  logic [2:0]          ret_cnt;
  logic [AWIDTH-1:0]   st_addr_q;
  logic [DWIDTH-1:0]   st_data_q;
  logic                gnt_d, gnt_s, gnt_i;
  logic                fill_act;

`ifdef MEM_ARB_FAIR_EN
  logic last_d;                        // 1: data side got the most recent grant

  always_comb begin
    gnt_d = 1'b0;
    gnt_s = 1'b0;
    gnt_i = 1'b0;
    if ((bus.d_miss || bus.st_req) && (!bus.i_miss || !last_d)) begin
      gnt_d = bus.d_miss;
      gnt_s = !bus.d_miss && bus.st_req;
    end else if (bus.i_miss) begin
      gnt_i = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == S_IDLE && (gnt_d || gnt_s || gnt_i)) begin
      last_d <= !gnt_i;
    end
  end
`else
  always_comb begin
    gnt_d = 1'b0;
    gnt_s = 1'b0;
    gnt_i = 1'b0;
    if (bus.d_miss)      gnt_d = 1'b1;
    else if (bus.st_req) gnt_s = 1'b1;
    else if (bus.i_miss) gnt_i = 1'b1;
  end
`endif

  assign fill_act = bus.mem_valid && (state == S_ISSUE || state == S_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (gnt_s)               state_nxt = S_STORE;
        else if (gnt_d || gnt_i) state_nxt = S_ISSUE;
      end
      S_STORE: state_nxt = S_IDLE;
      S_ISSUE: begin
        if (fill_act && ret_cnt == 3'd7) state_nxt = S_TAG;
        else if (issue_cnt == 3'd7)      state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (fill_act && ret_cnt == 3'd7) state_nxt = S_TAG;
      end
      S_TAG:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt_i     <= 1'b0;
      base_hi   <= '0;
      issue_cnt <= 3'd0;
      ret_cnt   <= 3'd0;
      st_addr_q <= '0;
      st_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && (gnt_d || gnt_i)) begin
        tgt_i     <= gnt_i;
        base_hi   <= gnt_i ? bus.i_miss_addr[AWIDTH-1:4] : bus.d_miss_addr[AWIDTH-1:4];
        issue_cnt <= 3'd0;
        ret_cnt   <= 3'd0;
      end
      // Store operands are registered so the write cycle has no input-to-output path.
      if (state == S_IDLE && gnt_s) begin
        st_addr_q <= bus.st_addr;
        st_data_q <= bus.st_data;
      end
      if (state == S_ISSUE) issue_cnt <= issue_cnt + 3'd1;
      if (fill_act)         ret_cnt   <= ret_cnt + 3'd1;
    end
  end

  always_comb begin
    bus.mem_en     = (state == S_ISSUE) || (state == S_STORE);
    bus.mem_wr     = (state == S_STORE);
    bus.mem_wdata  = (state == S_STORE) ? st_data_q : '0;
    bus.st_ack     = (state == S_STORE);
    bus.busy       = (state != S_IDLE);
    bus.d_fill_wen = fill_act && !tgt_i;
    bus.i_fill_wen = fill_act && tgt_i;
    bus.fill_word  = fill_act ? ret_cnt : 3'd0;
    bus.d_tag_wen  = (state == S_TAG) && !tgt_i;
    bus.i_tag_wen  = (state == S_TAG) && tgt_i;
    bus.mem_addr   = '0;
    // Base is 16-byte aligned, so the word offset can be concatenated without a carry.
    if (state == S_ISSUE)      bus.mem_addr = {base_hi, issue_cnt, 1'b0};
    else if (state == S_STORE) bus.mem_addr = st_addr_q;
  end

  assign state_dbg = state;

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

Sequencer and arbiter for the single-ported, pipelined main memory shared by the I-cache, the D-cache and write-through stores. Grants one requester at a time and issues the read addresses for an 8-word block fill. Steers returning memory words into the granted cache's data array and closes each fill with a one-cycle tag write. Sits between both cache instances and the memory model inside the memory system, replacing ad-hoc miss-address muxing.

## Interface
- AWIDTH, 16, byte address width
- DWIDTH, 16, word width
- MEM_LAT, 4, memory read latency in cycles (address cycle to data_valid)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- d_miss  in  1  D-cache miss pending; held until d_tag_wen
- d_miss_addr  in  AWIDTH  D-cache miss byte address
- i_miss  in  1  I-cache miss pending; held until i_tag_wen
- i_miss_addr  in  AWIDTH  I-cache miss byte address
- st_req  in  1  store write-through request; held until st_ack
- st_addr  in  AWIDTH  store byte address
- st_data  in  DWIDTH  store data
- mem_valid  in  1  memory read data valid
- mem_en  out  1  memory access enable
- mem_wr  out  1  memory write (1) / read (0)
- mem_addr  out  AWIDTH  memory byte address
- mem_wdata  out  DWIDTH  memory write data
- d_fill_wen  out  1  D-cache data-array write enable
- d_tag_wen  out  1  D-cache tag-array write enable
- i_fill_wen  out  1  I-cache data-array write enable
- i_tag_wen  out  1  I-cache tag-array write enable
- fill_word  out  3  word offset (0..7) of the word presented with *_fill_wen
- st_ack  out  1  store accepted, one-cycle pulse
- busy  out  1  state != IDLE

## Operation
- States: IDLE, STORE, ISSUE, DRAIN, TAG.
- IDLE arbitration, evaluated every IDLE cycle: d_miss > st_req > i_miss (fixed priority; see Configuration).
- Grant to a fill: latch tgt (D/I) and base = {addr[AWIDTH-1:4], 4'b0}. Clear issue_cnt and ret_cnt (3 bits each). Go to ISSUE.
- Grant to a store: go to STORE.
- STORE, one cycle: mem_en=1, mem_wr=1, mem_addr=st_addr, mem_wdata=st_data, st_ack=1. Go to IDLE.
- ISSUE: mem_en=1, mem_wr=0, mem_addr = base + {issue_cnt,1'b0}, issue_cnt++. After the cycle with issue_cnt==7, go to DRAIN.
- In ISSUE or DRAIN, each mem_valid asserts the tgt's fill_wen, drives fill_word=ret_cnt, and increments ret_cnt.
- The 8th mem_valid (ret_cnt==7) moves the block to TAG; it may fall in ISSUE or DRAIN.
- TAG, one cycle: tgt's tag_wen=1. Go to IDLE.
- Cache data_in is taken directly from memory data; this block does not buffer fill data.
- mem_valid in IDLE, STORE or TAG is ignored.
- A requester deasserting mid-fill does not abort the fill; the block is still written and tagged.
- New requests arriving while busy wait; they are evaluated in the next IDLE cycle.
- Address arithmetic is modulo 2^AWIDTH. Base alignment guarantees no carry out of bits [3:1].

## Timing
- Reset (asynchronous): state=IDLE, counters=0, tgt=D. All outputs 0, including mem_addr, mem_wdata and fill_word.
- Reset mid-fill: abort immediately, with no tag_wen.
- Request visible in IDLE at cycle T: first ISSUE at T+1; addresses at T+1..T+8.
- With MEM_LAT=4: data at T+5..T+12, tag_wen at T+13, IDLE at T+14.
- The earliest next grant is the IDLE cycle T+14.
- Store seen at T: write and st_ack at T+1; IDLE at T+2.
- All outputs are decoded from registered state; no combinational input-to-output path except fill_wen/fill_word from mem_valid.

## Configuration
- MEM_ARB_FAIR_EN defined: a last-grant bit (reset 0) alternates between the data side (d_miss/st_req, internally D > store) and i_miss when both sides request in the same IDLE cycle. The side not granted last wins.
- MEM_ARB_FAIR_EN undefined: strict fixed priority d_miss > st_req > i_miss. i_miss may starve.

## Test plan
- d_miss with d_miss_addr=0x1236 at T -> mem_addr 0x1230,0x1232..0x123E at T+1..T+8; d_fill_wen with fill_word 0..7 on the 8 mem_valid cycles; d_tag_wen only at T+13; no i_* enables.
- st_req addr=0x0040, data=0xBEEF -> one cycle with mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, st_ack=1; busy cleared next cycle.
- d_miss, st_req and i_miss all asserted together -> D fill, then store, then I fill, strictly serialized. With MEM_ARB_FAIR_EN and continuous d_miss, grants alternate D, I, D.
- rst pulsed at the 3rd return of a fill -> all outputs 0 immediately, no tag_wen; a re-asserted miss restarts from word 0.
- Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE with no wrap into 0x0000.
- Spurious mem_valid in IDLE and during STORE -> no fill_wen or tag_wen, state unchanged.
